// File: rtl/pad_cfg_sequencer.sv
// Per-pad configuration store: arbitrated writes into a shadow copy, then a
// group-by-group commit into the active copy with a settle gap after each changed group.
module pad_cfg_sequencer #(
  parameter int unsigned N_PADS        = 64,
  parameter int unsigned CFG_W         = 6,
  parameter int unsigned GROUP_SIZE    = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned IDX_W         = $clog2(N_PADS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            a_valid_i,
  output logic                            a_ready_o,
  input  logic [IDX_W-1:0]                a_idx_i,
  input  logic [CFG_W-1:0]                a_cfg_i,
  input  logic                            b_valid_i,
  output logic                            b_ready_o,
  input  logic [IDX_W-1:0]                b_idx_i,
  input  logic [CFG_W-1:0]                b_cfg_i,
  input  logic                            commit_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  input  logic [IDX_W-1:0]                rd_idx_i,
  output logic [CFG_W-1:0]                rd_shadow_o,
  output logic [N_PADS-1:0][CFG_W-1:0]    pad_cfg_o
);

  localparam int unsigned N_GROUPS = N_PADS / GROUP_SIZE;
  localparam int unsigned GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam int unsigned CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PW       = (N_PADS > 1) ? $clog2(N_PADS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SETTLE
  } state_t;

  state_t                       state;
  logic [GRP_W-1:0]             grp;
  logic [CNT_W-1:0]             cnt;
  logic                         last_b;
  logic [N_PADS-1:0][CFG_W-1:0] shadow;

  logic             a_fire;
  logic             b_fire;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [CFG_W-1:0] wr_cfg;
  logic             wr_idx_ok;
  logic             grp_diff;
  logic             last_grp;

  // Both requesting: the port that did not win last time gets the slot.
  always_comb begin
    a_ready_o = 1'b0;
    b_ready_o = 1'b0;
    if (!busy_o) begin
      if (a_valid_i && b_valid_i) begin
        a_ready_o = last_b;
        b_ready_o = !last_b;
      end else begin
        a_ready_o = a_valid_i;
        b_ready_o = b_valid_i;
      end
    end
  end

  assign a_fire    = a_valid_i && a_ready_o;
  assign b_fire    = b_valid_i && b_ready_o;
  assign wr_en     = a_fire || b_fire;
  assign wr_idx    = a_fire ? a_idx_i : b_idx_i;
  assign wr_cfg    = a_fire ? a_cfg_i : b_cfg_i;
  assign wr_idx_ok = 32'(wr_idx) < N_PADS;
  assign last_grp  = (grp == GRP_W'(N_GROUPS - 1));

  always_comb begin
    rd_shadow_o = '0;
    for (int unsigned i = 0; i < N_PADS; i++) begin
      if (rd_idx_i == IDX_W'(i)) rd_shadow_o = shadow[PW'(i)];
    end
  end

  always_comb begin
    grp_diff = 1'b0;
    for (int unsigned g = 0; g < N_GROUPS; g++) begin
      if (grp == GRP_W'(g)) begin
        for (int unsigned p = 0; p < GROUP_SIZE; p++) begin
          if (shadow[PW'(g * GROUP_SIZE + p)] != pad_cfg_o[PW'(g * GROUP_SIZE + p)])
            grp_diff = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      grp       <= '0;
      cnt       <= '0;
      last_b    <= 1'b1;
      shadow    <= '0;
      pad_cfg_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= wr_en && !wr_idx_ok;

      if (a_fire)      last_b <= 1'b0;
      else if (b_fire) last_b <= 1'b1;

      // Out-of-range indices match no entry, so the shadow is left untouched.
      if (wr_en) begin
        for (int unsigned i = 0; i < N_PADS; i++) begin
          if (wr_idx == IDX_W'(i)) shadow[PW'(i)] <= wr_cfg;
        end
      end

      case (state)
        IDLE: begin
          if (commit_i) begin
            state  <= SCAN;
            grp    <= '0;
            busy_o <= 1'b1;
          end
        end
        SCAN: begin
          if (grp_diff) begin
            for (int unsigned g = 0; g < N_GROUPS; g++) begin
              if (grp == GRP_W'(g)) begin
                for (int unsigned p = 0; p < GROUP_SIZE; p++)
                  pad_cfg_o[PW'(g * GROUP_SIZE + p)] <= shadow[PW'(g * GROUP_SIZE + p)];
              end
            end
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end else if (last_grp) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            if (last_grp) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              grp   <= grp + 1'b1;
              state <= SCAN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
